// File: rtl/mod6_count_ctrl.sv
`timescale 1ns/1ps
// ============================================================================
// mod6_count_ctrl
// ----------------------------------------------------------------------------
// Push-button controlled modulo-6 counter with a run/stop state machine.
// The count feeds a seven-segment decoder.
//
// Three asynchronous buttons (run, direction, clear) are each synchronized by
// two flops. They are optionally debounced, then edge-detected into one-cycle
// press pulses.
//
// A prescaler divides clk by DIV while the FSM is in RUN. Each prescaler
// terminal count advances the count by one step, up or down.
//
// Optional feature macro: MOD6_DEBOUNCE_EN
//   defined   : each button level must differ from the accepted level for
//               DEBOUNCE_CYCLES consecutive cycles before it is accepted
//   undefined : the accepted level is the synchronizer output, and no
//               debounce counters exist
//
// Parameters
//   DIV              clk cycles per count step (2 .. 2^32-1)
//   DEBOUNCE_CYCLES  stable samples needed to accept a level change
//                    (2 .. 2^24-1); only meaningful with MOD6_DEBOUNCE_EN
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   btn_run   in   async button, each press toggles run/stop
//   btn_dir   in   async button, each press toggles direction
//   btn_clr   in   async button, each press clears the count
//   q         out  registered count 0..5
//   step      out  registered one-cycle pulse when q advanced by counting
//   running   out  registered, 1 in RUN
//   dir_down  out  registered, 1 = counting down
// ============================================================================
module mod6_count_ctrl #(
    parameter int unsigned DIV             = 50000000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_run,
    input  logic       btn_dir,
    input  logic       btn_clr,
    output logic [2:0] q,
    output logic       step,
    output logic       running,
    output logic       dir_down
);

    // Elaboration-time guard on the parameter ranges.
    generate
        if (DIV < 2 || DEBOUNCE_CYCLES < 2) begin : g_param_check
            $error("mod6_count_ctrl: DIV and DEBOUNCE_CYCLES must both be >= 2");
        end
    endgenerate

    localparam int unsigned NBTN   = 3;
    localparam int unsigned BTN_RUN = 0;
    localparam int unsigned BTN_DIR = 1;
    localparam int unsigned BTN_CLR = 2;

    localparam logic [31:0] DIV_LAST = 32'(DIV - 1);

    // ------------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------------
    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] sync1_q;
    logic [NBTN-1:0] sync2_q;
    logic [NBTN-1:0] level;      // conditioned (accepted) button level
    logic [NBTN-1:0] prev_q;     // level one cycle ago, for edge detection
    logic [NBTN-1:0] armed_q;    // set once the button has been seen released
    logic [NBTN-1:0] press;      // one-cycle press pulses

    // The synchronizer is cleared by reset, so its output only reflects the
    // pins two edges later. vld_cnt_q marks when sync2_q holds real data.
    logic [1:0] vld_cnt_q;
    logic       sync_vld;

    assign btn_raw  = {btn_clr, btn_dir, btn_run};
    assign sync_vld = (vld_cnt_q == 2'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            vld_cnt_q <= 2'd0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            if (vld_cnt_q != 2'd2) begin
                vld_cnt_q <= vld_cnt_q + 2'd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
`ifdef MOD6_DEBOUNCE_EN
            localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);

            logic [23:0] db_cnt_q;
            logic        db_level_q;

            // Count consecutive cycles in which the synchronized level
            // disagrees with the accepted level. Any agreeing sample restarts
            // the count, so glitches shorter than DEBOUNCE_CYCLES are lost.
            always_ff @(posedge clk) begin
                if (reset) begin
                    db_cnt_q   <= '0;
                    db_level_q <= 1'b0;
                end else if (sync2_q[gi] == db_level_q) begin
                    db_cnt_q <= '0;
                end else if (db_cnt_q == DB_LAST) begin
                    db_level_q <= sync2_q[gi];
                    db_cnt_q   <= '0;
                end else begin
                    db_cnt_q <= db_cnt_q + 24'd1;
                end
            end

            assign level[gi] = db_level_q;
`else
            assign level[gi] = sync2_q[gi];
`endif

            // A button held through reset must be released before it counts.
            // Arming waits for the synchronizer to carry real data and for
            // both the raw synchronized and the accepted level to be low.
            always_ff @(posedge clk) begin
                if (reset) begin
                    prev_q[gi]  <= 1'b0;
                    armed_q[gi] <= 1'b0;
                end else begin
                    prev_q[gi] <= level[gi];
                    if (sync_vld && !sync2_q[gi] && !level[gi]) begin
                        armed_q[gi] <= 1'b1;
                    end
                end
            end

            assign press[gi] = level[gi] & ~prev_q[gi] & armed_q[gi];
        end
    endgenerate

    logic run_press;
    logic dir_press;
    logic clr_press;

    assign run_press = press[BTN_RUN];
    assign dir_press = press[BTN_DIR];
    assign clr_press = press[BTN_CLR];

    // ------------------------------------------------------------------------
    // Run/stop FSM, prescaler and mod-6 counter
    // ------------------------------------------------------------------------
    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_q;
    logic [31:0] presc_q;
    logic [2:0]  q_q;
    logic [2:0]  q_adv;
    logic        step_q;
    logic        running_q;
    logic        dir_down_q;
    logic        term_cnt;

    assign term_cnt = (state_q == ST_RUN) && (presc_q == DIV_LAST);

    // Next count value, using the direction currently in effect. Out-of-range
    // codes can never be produced; they map back into 0..5 regardless.
    always_comb begin
        q_adv = 3'd0;
        if (dir_down_q) begin
            if (q_q == 3'd0 || q_q > 3'd5) begin
                q_adv = 3'd5;
            end else begin
                q_adv = q_q - 3'd1;
            end
        end else begin
            if (q_q >= 3'd5) begin
                q_adv = 3'd0;
            end else begin
                q_adv = q_q + 3'd1;
            end
        end
    end

    // Presses are all evaluated against the pre-edge state. This means a
    // step that coincides with a direction press uses the old direction, and
    // a step that coincides with a run press still happens before stopping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_STOP;
            running_q  <= 1'b0;
            dir_down_q <= 1'b0;
            presc_q    <= '0;
            q_q        <= 3'd0;
            step_q     <= 1'b0;
        end else begin
            step_q <= 1'b0;

            // Clear wins over a coinciding terminal count: no step is issued.
            if (clr_press) begin
                q_q     <= 3'd0;
                presc_q <= '0;
            end else if (state_q == ST_RUN) begin
                if (term_cnt) begin
                    presc_q <= '0;
                    q_q     <= q_adv;
                    step_q  <= 1'b1;
                end else begin
                    presc_q <= presc_q + 32'd1;
                end
            end
            // In STOP the prescaler holds, so resuming keeps the phase.

            if (dir_press) begin
                dir_down_q <= ~dir_down_q;
            end

            if (run_press) begin
                case (state_q)
                    ST_STOP: begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                    default: begin
                        state_q   <= ST_STOP;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign q        = q_q;
    assign step     = step_q;
    assign running  = running_q;
    assign dir_down = dir_down_q;

endmodule

// File: tb/tb_mod6_count_ctrl.sv
`timescale 1ns/1ps
// Scoreboarded bench for mod6_count_ctrl with DIV=4, DEBOUNCE_CYCLES=8.
// Stimulus pushes the expected q for each step into exp_q; the monitor pops
// and compares whenever step is high. Direct checks cover non-step behaviour.
module tb_mod6_count_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_run = 1'b0;
    logic       btn_dir = 1'b0;
    logic       btn_clr = 1'b0;
    logic [2:0] q;
    logic       step;
    logic       running;
    logic       dir_down;

    int total = 0;
    int bad   = 0;
    int exp_q[$];

    mod6_count_ctrl #(
        .DIV            (4),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_run (btn_run),
        .btn_dir (btn_dir),
        .btn_clr (btn_clr),
        .q       (q),
        .step    (step),
        .running (running),
        .dir_down(dir_down)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got=%0d required=%0d t=%0t", name, act, req, $time);
        end else begin
            $display("check %s: %0d ok", name, act);
        end
    endtask

    // Monitor: every negedge out of reset, q must be in range, and each step
    // pulse is matched against the next queued expectation.
    always @(negedge clk) begin
        if (!reset) begin
            total++;
            if (q > 3'd5) begin
                bad++;
                $display("FAIL q_range: got=%0d required=0..5 t=%0t", q, $time);
            end
            if (step) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_step: got q=%0d required=no step t=%0t", q, $time);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    if (int'(q) != e) begin
                        bad++;
                        $display("FAIL step_q: got=%0d required=%0d t=%0t", q, e, $time);
                    end else begin
                        $display("step q=%0d ok t=%0t", q, $time);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Short btn_run pulse: toggles running without debounce, ignored with it.
    task automatic glitch_test();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(4);
        btn_run = 1'b1;
        tick(5);
        btn_run = 1'b0;
`ifdef MOD6_DEBOUNCE_EN
        chk("glitch_running", int'(running), 0);
`else
        chk("glitch_running", int'(running), 1);
`endif
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(4);
    endtask

    initial begin
        // Reset state
        tick(2);
        reset = 1'b0;
        chk("rst_q", int'(q), 0);
        chk("rst_step", int'(step), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_dir", int'(dir_down), 0);
        tick(4);

`ifdef MOD6_DEBOUNCE_EN
        glitch_test();
        tick(15);
        // 12-cycle press: accepted on edge 2+8+1 after the first sample.
        btn_run = 1'b1;
        tick(10);
        chk("db_running_early", int'(running), 0);
        tick(1);
        chk("db_running_late", int'(running), 1);
        tick(1);
        btn_run = 1'b0;
        reset   = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("db_rst_running", int'(running), 0);
        tick(4);
`else
        // Run, 28 cycles: seven steps at 4-cycle spacing.
        foreach (exp_q[i]) exp_q.delete(i);
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        exp_q.push_back(4); exp_q.push_back(5); exp_q.push_back(0);
        exp_q.push_back(1);
        btn_run = 1'b1;
        tick(3);
        chk("run_latency", int'(running), 1);
        chk("run_step0", int'(step), 0);
        btn_run = 1'b0;
        for (int k = 1; k <= 28; k++) begin
            tick(1);
            chk($sformatf("run_step_c%0d", k), int'(step), (k % 4 == 0) ? 1 : 0);
        end
        chk("run_q_end", int'(q), 1);

        // Direction press, then stop at q=3 mid-prescale and resume.
        btn_dir = 1'b1;
        tick(3);
        chk("dir_toggle", int'(dir_down), 1);
        exp_q.push_back(0); exp_q.push_back(5); exp_q.push_back(4); exp_q.push_back(3);
        btn_dir = 1'b0;
        tick(12);
        btn_run = 1'b1;
        tick(3);
        chk("stop_running", int'(running), 0);
        chk("stop_q", int'(q), 3);
        btn_run = 1'b0;
        tick(10);
        chk("stopped_q", int'(q), 3);
        btn_run = 1'b1;
        tick(3);
        chk("resume_running", int'(running), 1);
        exp_q.push_back(2);
        btn_run = 1'b0;
        tick(1);
        chk("resume_step_c1", int'(step), 0);
        tick(1);
        chk("resume_step_c2", int'(step), 1);
        chk("resume_q", int'(q), 2);

        // Clear coinciding with terminal count at q=2.
        tick(1);
        btn_clr = 1'b1;
        tick(3);
        chk("clr_q", int'(q), 0);
        chk("clr_step", int'(step), 0);
        chk("clr_running", int'(running), 1);
        chk("clr_dir", int'(dir_down), 1);
        btn_clr = 1'b0;
        exp_q.push_back(5);
        tick(4);
        chk("after_clr_step", int'(step), 1);

        // Run and dir presses coinciding with terminal count at q=5 (down).
        tick(1);
        btn_run = 1'b1;
        btn_dir = 1'b1;
        exp_q.push_back(4);
        tick(3);
        chk("both_step", int'(step), 1);
        chk("both_q", int'(q), 4);
        chk("both_running", int'(running), 0);
        chk("both_dir", int'(dir_down), 0);
        btn_run = 1'b0;
        btn_dir = 1'b0;
        tick(6);
        chk("both_hold_q", int'(q), 4);

        // Reset while RUN, dir_down=1, q=4, with btn_run held through it.
        btn_dir = 1'b1;
        tick(3);
        btn_dir = 1'b0;
        tick(4);
        btn_run = 1'b1;
        tick(3);
        chk("pre_rst_running", int'(running), 1);
        chk("pre_rst_dir", int'(dir_down), 1);
        chk("pre_rst_q", int'(q), 4);
        reset = 1'b1;
        tick(1);
        chk("rst2_q", int'(q), 0);
        chk("rst2_running", int'(running), 0);
        chk("rst2_dir", int'(dir_down), 0);
        chk("rst2_step", int'(step), 0);
        reset = 1'b0;
        tick(10);
        chk("held_no_press", int'(running), 0);
        btn_run = 1'b0;
        tick(4);
        btn_run = 1'b1;
        tick(3);
        chk("repress_running", int'(running), 1);
        btn_run = 1'b0;

        glitch_test();
`endif

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_steps: got=%0d pending required=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
